// File: rtl/iter_alu.sv
// EX-stage ALU: single-cycle logic/shift/arith ops plus an iterative
// shift-add multiplier and restoring divider that write HI/LO.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;
    localparam logic [5:0] F_LUI  = 6'b111101;
    // Narrow builds have no room for a 16-bit immediate; they shift by half width.
    localparam int LUI_SH = (WIDTH >= 32) ? 16 : WIDTH / 2;
    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q;
    logic [SHW:0]     cnt_q;
    logic             is_div_q, neg_res_q, neg_rem_q, dbz_run_q;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] wrk_q, wrk_d, opd_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, ovf_q, dbz_q, busy_q, done_q;

    // Returns {overflow, result} for every op that completes in one edge.
    function automatic logic [WIDTH:0] alu_op(input logic [5:0] f, input logic [SHW-1:0] sh,
                                              input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
        logic [WIDTH-1:0] r, s, d;
        logic signed [WIDTH-1:0] xs, ys;
        logic v;
        xs = x;
        ys = y;
        s  = x + y;
        d  = x - y;
        r  = '0;
        v  = 1'b0;
        case (f)
            F_SLL:  r = y << sh;
            F_SRL:  r = y >> sh;
            F_SRA:  r = $unsigned(ys >>> sh);
            F_SLLV: r = y << x[SHW-1:0];
            F_SRLV: r = y >> x[SHW-1:0];
            F_ADD: begin
                r = s;
                v = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
            end
            F_ADDU: r = s;
            F_SUB: begin
                r = d;
                v = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
            end
            F_SUBU: r = d;
            F_AND:  r = x & y;
            F_OR:   r = x | y;
            F_XOR:  r = x ^ y;
            F_NOR:  r = ~(x | y);
            F_SLT:  r = WIDTH'(xs < ys);
            F_SLTU: r = WIDTH'(x < y);
            F_LUI:  r = y << LUI_SH;
            F_MFHI: r = h;
            F_MFLO: r = l;
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction

    logic [WIDTH:0]     shifted, trial, psum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH:0]     op_res;
    logic               op_iter, op_signed, neg_a, neg_b;

    // One iteration step; acc holds the running product-high / partial remainder.
    always_comb begin
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        shifted = {acc_q[WIDTH-1:0], wrk_q[WIDTH-1]};
        trial   = shifted - {1'b0, opd_q};
        psum    = acc_q + (wrk_q[0] ? {1'b0, opd_q} : '0);
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                acc_d = trial;
                wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted;
                wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {1'b0, psum[WIDTH:1]};
            wrk_d = {psum[0], wrk_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod      = {acc_q[WIDTH-1:0], wrk_q};
        prod      = neg_res_q ? -prod : prod;
        quo       = neg_res_q ? -wrk_q : wrk_q;
        rem       = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        op_res    = alu_op(func, shamt, a, b, hi_q, lo_q);
        op_iter   = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);
        op_signed = !func[0];
        neg_a     = op_signed && a[WIDTH-1];
        neg_b     = op_signed && b[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_run_q <= 1'b0;
            acc_q     <= '0;
            wrk_q     <= '0;
            opd_q     <= '0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (op_iter) begin
                        is_div_q  <= func[1];
                        acc_q     <= '0;
                        wrk_q     <= func[1] ? abs_val(a, op_signed) : abs_val(b, op_signed);
                        opd_q     <= func[1] ? abs_val(b, op_signed) : abs_val(a, op_signed);
                        neg_res_q <= neg_a ^ neg_b;
                        neg_rem_q <= neg_a;
                        dbz_run_q <= (b == '0);
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        result_q <= op_res[WIDTH-1:0];
                        zero_q   <= (op_res[WIDTH-1:0] == '0);
                        ovf_q    <= op_res[WIDTH];
                        done_q   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    wrk_q <= wrk_d;
                    cnt_q <= cnt_q + (SHW + 1)'(1);
                    if (cnt_q == CNT_LAST) state_q <= FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        // Divide by zero leaves quotient all ones and remainder equal to a.
                        hi_q  <= rem;
                        lo_q  <= dbz_run_q ? '1 : quo;
                        dbz_q <= dbz_run_q;
                    end else begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: a vector table for single-cycle ops plus
// hand-written multiply/divide, handshake and reset sequences.
module tb_iter_alu;
    logic        clk = 1'b0;
    logic        rst_b, start;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [31:0] a, b, result, hi, lo;
    logic        zero, overflow, div_by_zero, busy, done;

    int checks = 0;
    int failures = 0;

    iter_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .func(func), .shamt(shamt),
        .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
        .div_by_zero(div_by_zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] va, vb, exp_r;
        logic        exp_z, exp_v;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        func = f; shamt = sh; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_iter(input string name, input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
        int n;
        issue(f, 5'd0, va, vb);
        check({name, " busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 64'(n), 64'd33);
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
        check({name, " lo"}, 64'(lo), 64'(exp_lo));
        check({name, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
        check({name, " busy end"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({name, " done single"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        vecs[0]  = '{"add ovf",   6'b100000, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{"addu",      6'b100001, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
        vecs[2]  = '{"sub zero",  6'b100010, 5'd0,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{"sub ovf",   6'b100010, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[4]  = '{"subu",      6'b100011, 5'd0,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[5]  = '{"add negov", 6'b100000, 5'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
        vecs[6]  = '{"sra",       6'b000011, 5'd4,  32'h00000000, 32'h80000000, 32'hF8000000, 1'b0, 1'b0};
        vecs[7]  = '{"srl",       6'b000010, 5'd4,  32'h00000000, 32'h80000000, 32'h08000000, 1'b0, 1'b0};
        vecs[8]  = '{"sll",       6'b000000, 5'd31, 32'h00000000, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
        vecs[9]  = '{"srlv",      6'b000110, 5'd0,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0};
        vecs[10] = '{"sllv",      6'b000100, 5'd0,  32'h00000024, 32'h00000003, 32'h00000030, 1'b0, 1'b0};
        vecs[11] = '{"lui",       6'b111101, 5'd0,  32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0};
        vecs[12] = '{"slt",       6'b101010, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[13] = '{"sltu",      6'b101011, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{"and",       6'b100100, 5'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
        vecs[15] = '{"xor",       6'b100110, 5'd0,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0};
        vecs[16] = '{"nor",       6'b100111, 5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[17] = '{"illegal",   6'b111111, 5'd0,  32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0};

        rst_b = 1'b1; start = 1'b0; func = '0; shamt = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        check("reset result", 64'(result), 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset flags", {59'd0, zero, overflow, div_by_zero, busy, done}, 64'd0);

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].f, vecs[i].sh, vecs[i].va, vecs[i].vb);
            check({vecs[i].name, " result"}, 64'(result), 64'(vecs[i].exp_r));
            check({vecs[i].name, " zero"}, 64'(zero), 64'(vecs[i].exp_z));
            check({vecs[i].name, " overflow"}, 64'(overflow), 64'(vecs[i].exp_v));
            check({vecs[i].name, " done"}, 64'(done), 64'd1);
        end
        @(posedge clk); #1;
        check("idle done low", 64'(done), 64'd0);

        issue(6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1);
        held = result;
        run_iter("mult", 6'b011000, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        check("mult keeps result", 64'(result), 64'(held));
        check("mult clears ovf", 64'(overflow), 64'd0);
        issue(6'b010010, 5'd0, 32'h0, 32'h0);
        check("mflo result", 64'(result), 64'hFFFFFFFA);
        check("mflo zero", 64'(zero), 64'd0);
        issue(6'b010000, 5'd0, 32'h0, 32'h0);
        check("mfhi result", 64'(result), 64'hFFFFFFFF);

        run_iter("multu", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_iter("div -7/2", 6'b011010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_iter("div 7/-2", 6'b011010, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_iter("divu 100/7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_iter("divu 5/0", 6'b011011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
        issue(6'b100001, 5'd0, 32'd1, 32'd1);
        check("dbz holds", 64'(div_by_zero), 64'd1);
        run_iter("divu 6/3", 6'b011011, 32'd6, 32'd3, 32'd0, 32'd2, 1'b0);
        run_iter("div -5/0", 6'b011010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        run_iter("div minneg", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

        // Start is ignored mid-divide, then reset abandons the divide.
        issue(6'b011011, 5'd0, 32'd100, 32'd7);
        held = result;
        n = 0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin
                @(negedge clk);
                func = 6'b100000; a = 32'd9; b = 32'd9; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) n++;
        end
        check("busy ignores start done", 64'(n), 64'd0);
        check("busy ignores start result", 64'(result), 64'(held));
        check("still busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi/lo", {hi, lo}, 64'd0);
        check("abort done", 64'(done), 64'd0);
        issue(6'b100000, 5'd0, 32'd2, 32'd3);
        check("post reset add", 64'(result), 64'd5);
        check("post reset done", 64'(done), 64'd1);
        @(posedge clk); #1;
        check("post reset done once", 64'(done), 64'd0);
        check("post reset stays idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
